// File: rtl/ext_pkg.sv
// Shared extension-mode encodings, default datapath widths and the extend helper
// reused by the decode immediate path and the branch-offset path.
package ext_pkg;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    // Pure bit replication: upper bits are the input MSB when signing, zero otherwise.
    function automatic logic [WORD_W-1:0] ext_fn(input logic [IMM_W-1:0] x, input logic op);
        return {{(WORD_W-IMM_W){(op == EXT_SIGN) & x[IMM_W-1]}}, x};
    endfunction

endpackage

// File: rtl/ext.sv
// Immediate extender: zero/sign-extends imm16 to OUT_W bits, registered for 1-cycle latency.
// No back-pressure; a new immediate is accepted every cycle in_valid is high.
module ext
    import ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  imm16,
    input  logic             ExtOp,
    input  logic             in_valid,
    output logic [OUT_W-1:0] imm32,
    output logic             out_valid
);

    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_imm32;
    logic             r_out_valid;

    generate
        if (OUT_W > IN_W) begin : g_wide
            assign w_ext = {{(OUT_W-IN_W){(ExtOp == EXT_SIGN) & imm16[IN_W-1]}}, imm16};
        end else begin : g_same
            // Equal widths leave nothing to extend, so the mode bit has no effect.
            assign w_ext = imm16;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm32     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_imm32 <= w_ext;
            end
        end
    end

    assign imm32     = r_imm32;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ext.sv
// Scoreboard bench for ext: stimulus pushes expected words, a negedge monitor pops on out_valid.
module tb_ext;

    logic        clk;
    logic        rst_n;
    logic [15:0] imm16;
    logic        ExtOp;
    logic        in_valid;
    logic [31:0] imm32;
    logic        out_valid;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    ext #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imm16     (imm16),
        .ExtOp     (ExtOp),
        .in_valid  (in_valid),
        .imm32     (imm32),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Drive one accepted immediate; its edge is the next posedge.
    task automatic issue(input logic [15:0] d, input logic op, input logic [31:0] exp);
        imm16    = d;
        ExtOp    = op;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got %h, expected no output", imm32);
            end else begin
                check("scoreboard", imm32, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        imm16    = 16'h0;
        ExtOp    = 1'b0;
        in_valid = 1'b0;
        #2;
        check("reset_imm32", imm32, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(16'h8000, 1'b0, 32'h0000_8000);
        issue(16'h8000, 1'b1, 32'hFFFF_8000);
        issue(16'hFFFF, 1'b1, 32'hFFFF_FFFF);
        issue(16'h7FFF, 1'b1, 32'h0000_7FFF);
        issue(16'hFFFF, 1'b0, 32'h0000_FFFF);

        issue(16'h1234, 1'b1, 32'h0000_1234);
        imm16    = 16'hABCD;
        ExtOp    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hold_imm32", imm32, 32'h0000_1234);
        check("hold_valid", {31'b0, out_valid}, 32'h0);

        // Pulse reset between edges right after a value has landed.
        issue(16'h8000, 1'b1, 32'hFFFF_8000);
        in_valid = 1'b0;
        #6;
        rst_n = 1'b0;
        #1;
        check("async_rst_imm32", imm32, 32'h0);
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(16'h0042, 1'b1, 32'h0000_0042);
        issue(16'h8001, 1'b0, 32'h0000_8001);

        for (int i = 0; i < 6; i++) begin
            issue(16'h8000, i[0], i[0] ? 32'hFFFF_8000 : 32'h0000_8000);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
